// File: rtl/ff_pkg.sv
// Shared helpers for the pipelined find-first-set engine.
// Integer math used to size the radix tree and its pipeline.
package ff_pkg;

    function automatic int pow(input int base, input int exp);
        int r;
        r = 1;
        for (int i = 0; i < exp; i++) begin
            r = r * base;
        end
        return r;
    endfunction

    function automatic int clog(input int val, input int base);
        int e;
        int p;
        e = 0;
        p = 1;
        while (p < val) begin
            p = p * base;
            e++;
        end
        return e;
    endfunction

    // Node count at a tree level; level 0 is the leaf bits.
    function automatic int num_blks(input int w, input int level, input int bw);
        return w / pow(bw, level);
    endfunction

    function automatic int n_stage(input int vw, input int bw, input int lps);
        return (clog(vw, bw) + lps - 1) / lps;
    endfunction

endpackage

// File: rtl/ff_block.sv
// One radix node: OR of child valids, index of the lowest valid child.
// Indices are carried at full width with the selector placed at SHIFT.
module ff_block #(
    parameter int BW    = 4,
    parameter int IW    = 7,
    parameter int SHIFT = 0
) (
    input  logic [BW-1:0]    i_valid,
    input  logic [BW*IW-1:0] i_ind,
    output logic             o_valid,
    output logic [IW-1:0]    o_ind
);

    always_comb begin
        o_valid = |i_valid;
        o_ind   = '0;
        for (int i = BW - 1; i >= 0; i--) begin
            if (i_valid[i]) begin
                o_ind = i_ind[i*IW +: IW] | (IW'(i) << SHIFT);
            end
        end
    end

endmodule

// File: rtl/ff_set_stage.sv
// A group of tree levels followed by one stall-able pipeline register.
// Start and tag ride along so the final add sees matching operands.
module ff_set_stage
    import ff_pkg::*;
#(
    parameter int VECT_WIDTH     = 128,
    parameter int VECT_IND_WIDTH = 7,
    parameter int BLOCK_WIDTH    = 4,
    parameter int TAG_WIDTH      = 8,
    parameter int LEVEL_LO       = 0,
    parameter int NUM_LEVELS     = 1,
    localparam int IW   = VECT_IND_WIDTH,
    localparam int LOGB = clog(BLOCK_WIDTH, 2),
    localparam int NI   = num_blks(VECT_WIDTH, LEVEL_LO, BLOCK_WIDTH),
    localparam int NO   = num_blks(VECT_WIDTH, LEVEL_LO + NUM_LEVELS,
                                   BLOCK_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic                 i_valid,
    input  logic [NI-1:0]        i_nvalid,
    input  logic [NI*IW-1:0]     i_nind,
    input  logic [IW-1:0]        i_start,
    input  logic [TAG_WIDTH-1:0] i_tag,
    output logic                 o_valid,
    output logic [NO-1:0]        o_nvalid,
    output logic [NO*IW-1:0]     o_nind,
    output logic [IW-1:0]        o_start,
    output logic [TAG_WIDTH-1:0] o_tag
);

    logic [NO-1:0]        w_nv;
    logic [NO*IW-1:0]     w_ni;

    logic                 r_valid;
    logic [NO-1:0]        r_nv;
    logic [NO*IW-1:0]     r_ni;
    logic [IW-1:0]        r_start;
    logic [TAG_WIDTH-1:0] r_tag;

    for (genvar l = 0; l < NUM_LEVELS; l++) begin : g_lvl
        localparam int LI = num_blks(VECT_WIDTH, LEVEL_LO + l, BLOCK_WIDTH);
        localparam int LO = LI / BLOCK_WIDTH;

        logic [LI-1:0]    w_vi;
        logic [LI*IW-1:0] w_ii;
        logic [LO-1:0]    w_vo;
        logic [LO*IW-1:0] w_io;

        if (l == 0) begin : g_first
            assign w_vi = i_nvalid;
            assign w_ii = i_nind;
        end else begin : g_chain
            assign w_vi = g_lvl[l-1].w_vo;
            assign w_ii = g_lvl[l-1].w_io;
        end

        for (genvar n = 0; n < LO; n++) begin : g_node
            ff_block #(
                .BW    (BLOCK_WIDTH),
                .IW    (IW),
                .SHIFT ((LEVEL_LO + l) * LOGB)
            ) u_blk (
                .i_valid (w_vi[n*BLOCK_WIDTH +: BLOCK_WIDTH]),
                .i_ind   (w_ii[n*BLOCK_WIDTH*IW +: BLOCK_WIDTH*IW]),
                .o_valid (w_vo[n]),
                .o_ind   (w_io[n*IW +: IW])
            );
        end
    end

    assign w_nv = g_lvl[NUM_LEVELS-1].w_vo;
    assign w_ni = g_lvl[NUM_LEVELS-1].w_io;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_nv    <= '0;
            r_ni    <= '0;
            r_start <= '0;
            r_tag   <= '0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_nv    <= w_nv;
            r_ni    <= w_ni;
            r_start <= i_start;
            r_tag   <= i_tag;
        end
    end

    assign o_valid  = r_valid;
    assign o_nvalid = r_nv;
    assign o_nind   = r_ni;
    assign o_start  = r_start;
    assign o_tag    = r_tag;

endmodule

// File: rtl/ff_set_pipe.sv
// Pipelined windowed find-first-set: rotate by start, reduce, add back.
// A single global enable stalls every stage when the output is blocked.
module ff_set_pipe
    import ff_pkg::*;
#(
    parameter int VECT_WIDTH       = 128,
    parameter int VECT_IND_WIDTH   = 7,
    parameter int BLOCK_WIDTH      = 4,
    parameter int LEVELS_PER_STAGE = 1,
    parameter int TAG_WIDTH        = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [VECT_WIDTH-1:0]     in_vect,
    input  logic [VECT_IND_WIDTH-1:0] in_start,
    input  logic                      in_wrap,
    input  logic [TAG_WIDTH-1:0]      in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_found,
    output logic [VECT_IND_WIDTH-1:0] out_ind,
    output logic [TAG_WIDTH-1:0]      out_tag
);

    localparam int IW          = VECT_IND_WIDTH;
    localparam int BLOCK_DEPTH = clog(VECT_WIDTH, BLOCK_WIDTH);
    localparam int NSTAGE      = n_stage(VECT_WIDTH, BLOCK_WIDTH,
                                         LEVELS_PER_STAGE);

    logic                  w_en;
    logic [IW:0]           w_shl;
    logic [VECT_WIDTH-1:0] w_rot;
    logic [VECT_WIDTH-1:0] w_mask;
    logic [VECT_WIDTH-1:0] w_vec0;

    logic                  r_valid0;
    logic [VECT_WIDTH-1:0] r_vec0;
    logic [IW-1:0]         r_start0;
    logic [TAG_WIDTH-1:0]  r_tag0;

    logic                  w_root_vld;
    logic                  w_root_v;
    logic [IW-1:0]         w_root_ind;
    logic [IW-1:0]         w_root_start;
    logic [TAG_WIDTH-1:0]  w_root_tag;

    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    // Bit in_start lands at position 0; the left shift supplies the wrap.
    assign w_shl  = (IW+1)'(VECT_WIDTH) - {1'b0, in_start};
    assign w_rot  = (in_vect >> in_start) | (in_vect << w_shl);
    assign w_mask = {VECT_WIDTH{1'b1}} >> in_start;
    assign w_vec0 = in_wrap ? w_rot : (w_rot & w_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid0 <= 1'b0;
            r_vec0   <= '0;
            r_start0 <= '0;
            r_tag0   <= '0;
        end else if (w_en) begin
            r_valid0 <= in_valid;
            r_vec0   <= w_vec0;
            r_start0 <= in_start;
            r_tag0   <= in_tag;
        end
    end

    for (genvar s = 0; s < NSTAGE; s++) begin : g_stg
        localparam int LO = s * LEVELS_PER_STAGE;
        localparam int NL = (BLOCK_DEPTH - LO < LEVELS_PER_STAGE) ?
                            (BLOCK_DEPTH - LO) : LEVELS_PER_STAGE;
        localparam int NI = num_blks(VECT_WIDTH, LO, BLOCK_WIDTH);
        localparam int NO = num_blks(VECT_WIDTH, LO + NL, BLOCK_WIDTH);

        logic                 w_vi;
        logic [NI-1:0]        w_nvi;
        logic [NI*IW-1:0]     w_nii;
        logic [IW-1:0]        w_si;
        logic [TAG_WIDTH-1:0] w_ti;
        logic                 w_vo;
        logic [NO-1:0]        w_nvo;
        logic [NO*IW-1:0]     w_nio;
        logic [IW-1:0]        w_so;
        logic [TAG_WIDTH-1:0] w_to;

        if (s == 0) begin : g_head
            assign w_vi  = r_valid0;
            assign w_nvi = r_vec0;
            assign w_nii = '0;
            assign w_si  = r_start0;
            assign w_ti  = r_tag0;
        end else begin : g_chain
            assign w_vi  = g_stg[s-1].w_vo;
            assign w_nvi = g_stg[s-1].w_nvo;
            assign w_nii = g_stg[s-1].w_nio;
            assign w_si  = g_stg[s-1].w_so;
            assign w_ti  = g_stg[s-1].w_to;
        end

        ff_set_stage #(
            .VECT_WIDTH     (VECT_WIDTH),
            .VECT_IND_WIDTH (VECT_IND_WIDTH),
            .BLOCK_WIDTH    (BLOCK_WIDTH),
            .TAG_WIDTH      (TAG_WIDTH),
            .LEVEL_LO       (LO),
            .NUM_LEVELS     (NL)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .i_en     (w_en),
            .i_valid  (w_vi),
            .i_nvalid (w_nvi),
            .i_nind   (w_nii),
            .i_start  (w_si),
            .i_tag    (w_ti),
            .o_valid  (w_vo),
            .o_nvalid (w_nvo),
            .o_nind   (w_nio),
            .o_start  (w_so),
            .o_tag    (w_to)
        );
    end

    assign w_root_vld   = g_stg[NSTAGE-1].w_vo;
    assign w_root_v     = g_stg[NSTAGE-1].w_nvo[0];
    assign w_root_ind   = g_stg[NSTAGE-1].w_nio;
    assign w_root_start = g_stg[NSTAGE-1].w_so;
    assign w_root_tag   = g_stg[NSTAGE-1].w_to;

    assign out_valid = w_root_vld;
    assign out_found = w_root_vld && w_root_v;
    assign out_ind   = out_found ? (w_root_ind + w_root_start) : '0;
    assign out_tag   = w_root_tag;

endmodule

// File: tb/tb_ff_set_pipe.sv
// Scoreboard bench for ff_set_pipe at VECT_WIDTH=16, radix 2, two levels/stage.
// Driver queues expected results on accept; a monitor retires them.
module tb_ff_set_pipe;

    localparam int VW = 16;
    localparam int IW = 4;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [VW-1:0] in_vect = '0;
    logic [IW-1:0] in_start = '0;
    logic          in_wrap = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_found;
    logic [IW-1:0] out_ind;
    logic [TW-1:0] out_tag;

    typedef struct {
        logic          found;
        logic [IW-1:0] ind;
        logic [TW-1:0] tag;
        int            cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   chk_lat = 1'b0;
    bit   rnd_ready = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end

    ff_set_pipe #(
        .VECT_WIDTH       (VW),
        .VECT_IND_WIDTH   (IW),
        .BLOCK_WIDTH      (2),
        .LEVELS_PER_STAGE (2),
        .TAG_WIDTH        (TW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vect   (in_vect),
        .in_start  (in_start),
        .in_wrap   (in_wrap),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_found (out_found),
        .out_ind   (out_ind),
        .out_tag   (out_tag)
    );

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [VW-1:0] v, input int s,
                                   input bit w, input logic [TW-1:0] t);
        exp_t e;
        e.found = 1'b0;
        e.ind   = '0;
        e.tag   = t;
        e.cyc   = 0;
        for (int k = 0; k < VW; k++) begin
            int idx;
            idx = (s + k) % VW;
            if (!e.found && v[idx] && (w || idx >= s)) begin
                e.found = 1'b1;
                e.ind   = IW'(idx);
            end
        end
        return e;
    endfunction

    // Called at a falling edge; returns at the falling edge after accept.
    task automatic send(input logic [VW-1:0] v, input logic [IW-1:0] s,
                        input bit w, input logic [TW-1:0] t,
                        input bit ef, input logic [IW-1:0] ei);
        exp_t e;
        bit   acc;
        acc      = 1'b0;
        in_vect  = v;
        in_start = s;
        in_wrap  = w;
        in_tag   = t;
        in_valid = 1'b1;
        e.found  = ef;
        e.ind    = ei;
        e.tag    = t;
        e.cyc    = 0;
        for (int n = 0; n < 200 && !acc; n++) begin
            #1;
            if (in_ready) begin
                acc   = 1'b1;
                e.cyc = cyc;
                q.push_back(e);
            end
            @(negedge clk);
        end
        if (!acc) chk("send_accept", 0, 1);
    endtask

    task automatic send_rnd(input logic [TW-1:0] t);
        logic [VW-1:0] v;
        logic [IW-1:0] s;
        bit            w;
        exp_t          m;
        v = VW'($urandom);
        s = IW'($urandom_range(0, VW - 1));
        w = 1'($urandom_range(0, 1));
        m = model(v, int'(s), w, t);
        send(v, s, w, t, m.found, m.ind);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int n = 0; n < 500 && q.size() > 0; n++) @(negedge clk);
        chk("drain_left", q.size(), 0);
    endtask

    initial begin : monitor
        exp_t          e;
        bit            pst;
        logic          pv;
        logic          pf;
        logic [IW-1:0] pi;
        logic [TW-1:0] pt;
        pst = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                pst = 1'b0;
            end else begin
                if (pst) begin
                    chk("hold_valid", out_valid, pv);
                    chk("hold_found", out_found, pf);
                    chk("hold_ind", out_ind, pi);
                    chk("hold_tag", out_tag, pt);
                end
                chk("in_ready", in_ready, !out_valid || out_ready);
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out: tag=%0h with none pending",
                                 out_tag);
                    end else begin
                        e = q.pop_front();
                        chk("found", out_found, e.found);
                        chk("ind", out_ind, e.ind);
                        chk("tag", out_tag, e.tag);
                        if (chk_lat) chk("latency", cyc - e.cyc, 3);
                    end
                end
                pst = out_valid && !out_ready;
                pv  = out_valid;
                pf  = out_found;
                pi  = out_ind;
                pt  = out_tag;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_found", out_found, 0);
        chk("rst_out_ind", out_ind, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk_lat = 1'b1;
        send(16'h0090, 4'd0, 1'b1, 8'h11, 1'b1, 4'd4);
        send(16'h0090, 4'd5, 1'b1, 8'h12, 1'b1, 4'd7);
        send(16'h0090, 4'd8, 1'b1, 8'h13, 1'b1, 4'd4);
        send(16'h0090, 4'd8, 1'b0, 8'h14, 1'b0, 4'd0);
        send(16'h8000, 4'd15, 1'b0, 8'h15, 1'b1, 4'd15);
        send(16'h0001, 4'd15, 1'b1, 8'h16, 1'b1, 4'd0);
        send(16'h0000, 4'd3, 1'b1, 8'h17, 1'b0, 4'd0);
        send(16'h0001, 4'd15, 1'b0, 8'h18, 1'b0, 4'd0);
        send(16'hFFFF, 4'd9, 1'b0, 8'h19, 1'b1, 4'd9);
        send(16'h0100, 4'd8, 1'b0, 8'h1A, 1'b1, 4'd8);
        drain();

        for (int i = 0; i < 20; i++) send_rnd(TW'(8'h40 + i));
        drain();

        chk_lat   = 1'b0;
        rnd_ready = 1'b1;
        for (int i = 0; i < 40; i++) send_rnd(TW'(8'h80 + i));
        drain();
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);

        out_ready = 1'b0;
        send(16'h0002, 4'd0, 1'b1, 8'hA1, 1'b1, 4'd1);
        send(16'h0004, 4'd0, 1'b1, 8'hA2, 1'b1, 4'd2);
        send(16'h0008, 4'd0, 1'b1, 8'hA3, 1'b1, 4'd3);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        q.delete();
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        chk_lat   = 1'b1;
        send(16'h0400, 4'd2, 1'b0, 8'hD0, 1'b1, 4'd10);
        drain();
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
